// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame constants
// and the parity helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;
    localparam int unsigned DATA_BITS_MAX  = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } rx_state_t;

    // Parity bit for a right-aligned character whose unused upper bits are zero.
    function automatic logic parity_calc(input logic [DATA_BITS_MAX-1:0] data,
                                         input logic odd);
        return odd ^ (^data);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// reset to RESET_VAL so the output never shows a spurious edge after reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchronises rx_in, qualifies the start bit at its
// centre, samples data/parity/stop from the oversampled tick and presents one byte per frame.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic                 de_strtbit,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [OS_W-1:0]      os_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 need_high;
    logic                 rx_s;
    logic                 bit_centre;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_s)
    );

    assign bit_centre = (os_cnt == OS_LAST);

    // Frame FSM; everything advances only on baud_tick, pulses last one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            os_cnt        <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_err       <= 1'b0;
            need_high     <= 1'b0;
            de_strtbit    <= 1'b0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
            data_out      <= '0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            de_strtbit <= 1'b0;
            data_valid <= 1'b0;
            if (baud_tick) begin
                unique case (state)
                    IDLE: begin
                        // After a low stop bit, a break must end before a new start counts.
                        if (need_high) begin
                            if (rx_s) begin
                                need_high <= 1'b0;
                            end
                        end else if (!rx_s) begin
                            state  <= START;
                            os_cnt <= '0;
                            busy   <= 1'b1;
                        end
                    end
                    START: begin
                        if (os_cnt == OS_MID) begin
                            if (!rx_s) begin
                                de_strtbit <= 1'b1;
                                os_cnt     <= '0;
                                bit_cnt    <= '0;
                                state      <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_centre) begin
                            os_cnt <= '0;
                            shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_centre) begin
                            os_cnt  <= '0;
                            par_err <= parity_calc(DATA_BITS_MAX'(shreg), PARITY_ODD != 0) ^ rx_s;
                            state   <= STOP;
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                    STOP: begin
                        if (bit_centre) begin
                            os_cnt        <= '0;
                            data_out      <= shreg;
                            parity_error  <= par_err;
                            framing_error <= !rx_s;
                            need_high     <= !rx_s;
                            data_valid    <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend (8E1, 16x): tick-indexed expectation model plus
// directed frames with literal expected results.
module tb_uart_rx_frontend;

    localparam int OS          = 16;
    localparam int DB          = 8;
    localparam int PE          = 1;
    localparam int PODD        = 0;
    localparam int TICK_DIV    = 4;
    localparam int FRAME_TICKS = (1 + DB + PE + 1) * OS;
    localparam int MAXT        = 8192;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          baud_tick = 1'b0;
    logic          rx_in     = 1'b1;
    logic          de_strtbit;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          parity_error;
    logic          framing_error;
    logic          busy;

    uart_rx_frontend #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .PARITY_EN  (PE),
        .PARITY_ODD (PODD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .baud_tick     (baud_tick),
        .rx_in         (rx_in),
        .de_strtbit    (de_strtbit),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Baud tick every TICK_DIV clocks; freeze suppresses ticks entirely.
    int div    = 0;
    bit freeze = 1'b0;
    always @(negedge clk) begin
        div       = (div == TICK_DIV - 1) ? 0 : div + 1;
        baud_tick = (div == 0) && !freeze;
    end

    // Expectations keyed by tick index: what must be visible right after that tick edge.
    bit            exp_start [MAXT];
    bit            exp_valid [MAXT];
    bit            busy_on   [MAXT];
    bit            busy_off  [MAXT];
    logic [DB-1:0] exp_data  [MAXT];
    bit            exp_pe    [MAXT];
    bit            exp_fe    [MAXT];

    int            tick_cnt = 0;
    int            cyc      = 0;
    int            errors   = 0;
    int            checks   = 0;
    int            dv_count = 0;
    int            de_count = 0;
    int            last_dv  = 0;
    int            prev_dv  = 0;
    logic          m_busy   = 1'b0;
    logic [DB-1:0] m_data   = '0;
    logic          m_pe     = 1'b0;
    logic          m_fe     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single compare process, sampled 1 time unit after every active edge.
    always @(posedge clk) begin
        logic e_de;
        logic e_dv;
        #1;
        cyc++;
        e_de = 1'b0;
        e_dv = 1'b0;
        if (baud_tick) tick_cnt++;
        if (reset) begin
            m_busy = 1'b0;
            m_data = '0;
            m_pe   = 1'b0;
            m_fe   = 1'b0;
        end else if (baud_tick && tick_cnt < MAXT) begin
            e_de = exp_start[tick_cnt];
            e_dv = exp_valid[tick_cnt];
            if (busy_on[tick_cnt])  m_busy = 1'b1;
            if (busy_off[tick_cnt]) m_busy = 1'b0;
            if (e_dv) begin
                m_data = exp_data[tick_cnt];
                m_pe   = exp_pe[tick_cnt];
                m_fe   = exp_fe[tick_cnt];
            end
        end
        check("de_strtbit",    de_strtbit,    e_de);
        check("data_valid",    data_valid,    e_dv);
        check("busy",          busy,          m_busy);
        check("data_out",      data_out,      m_data);
        check("parity_error",  parity_error,  m_pe);
        check("framing_error", framing_error, m_fe);
        if (de_strtbit === 1'b1) de_count++;
        if (data_valid === 1'b1) begin
            dv_count++;
            prev_dv = last_dv;
            last_dv = cyc;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic bit_slot(input logic v, input int n, input bit pause);
        @(negedge clk) rx_in = v;
        if (pause) begin
            wait_ticks(n / 2);
            freeze = 1'b1;
            repeat (40) @(posedge clk);
            freeze = 1'b0;
            wait_ticks(n - n / 2);
        end else begin
            wait_ticks(n);
        end
    endtask

    // Sends one frame and records its expected start pulse, busy window and result.
    task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic stop,
                              input int stop_ticks, input int pause_bit);
        int t0;
        int tq;
        int ts;
        @(negedge clk) rx_in = 1'b0;
        t0 = tick_cnt + 1;
        tq = t0 + OS / 2;
        ts = tq + (DB + PE + 1) * OS;
        busy_on[t0]   = 1'b1;
        exp_start[tq] = 1'b1;
        exp_valid[ts] = 1'b1;
        busy_off[ts]  = 1'b1;
        exp_data[ts]  = d;
        exp_pe[ts]    = (PE != 0) && ((($countones(d) + int'(pbit)) % 2) != PODD);
        exp_fe[ts]    = !stop;
        wait_ticks(OS);
        for (int i = 0; i < DB; i++) bit_slot(d[i], OS, i == pause_bit);
        if (PE != 0) bit_slot(pbit, OS, 1'b0);
        bit_slot(stop, stop_ticks, 1'b0);
    endtask

    task automatic pin(input string tag, input logic [7:0] d, input logic pe, input logic fe,
                       input int n);
        #2;
        check({tag, "_data"},   data_out,      d);
        check({tag, "_perr"},   parity_error,  pe);
        check({tag, "_ferr"},   framing_error, fe);
        check({tag, "_valids"}, dv_count,      n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DB-1:0] d12;
        int            t0;
        d12 = 8'h12;

        repeat (4) @(posedge clk);
        #2;
        check("rst_busy",     busy,          0);
        check("rst_valid",    data_valid,    0);
        check("rst_start",    de_strtbit,    0);
        check("rst_data_out", data_out,      0);
        check("rst_perr",     parity_error,  0);
        check("rst_ferr",     framing_error, 0);
        @(negedge clk) reset = 1'b0;
        wait_ticks(OS);

        // Clean 8E1 frame, with ticks frozen for a while in the middle of bit 3.
        send_frame(8'hA5, 1'b0, 1'b1, OS, 3);
        pin("a5", 8'hA5, 1'b0, 1'b0, 1);
        check("a5_starts", de_count, 1);

        // Wrong parity bit under even parity.
        send_frame(8'h01, 1'b0, 1'b1, OS, -1);
        pin("p01", 8'h01, 1'b1, 1'b0, 2);

        // Low stop bit, then the line stays low for three frame times.
        send_frame(8'h3C, 1'b0, 1'b0, OS, -1);
        pin("f3c", 8'h3C, 1'b0, 1'b1, 3);
        wait_ticks(3 * FRAME_TICKS);
        check("break_valids", dv_count, 3);
        check("break_starts", de_count, 3);
        check("break_busy",   busy,     0);
        bit_slot(1'b1, OS, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, OS, -1);
        pin("c3", 8'hC3, 1'b0, 1'b0, 4);

        // Four-tick glitch: START entered, then abandoned at the half-bit check.
        @(negedge clk) rx_in = 1'b0;
        t0 = tick_cnt + 1;
        busy_on[t0]           = 1'b1;
        busy_off[t0 + OS / 2] = 1'b1;
        wait_ticks(4);
        bit_slot(1'b1, 2 * OS, 1'b0);
        #2;
        check("glitch_busy",   busy,     0);
        check("glitch_starts", de_count, 4);
        check("glitch_valids", dv_count, 4);

        // Back-to-back frames with no idle gap: 11 bit periods of 64 clks each.
        send_frame(8'h55, 1'b0, 1'b1, OS, -1);
        send_frame(8'hFF, 1'b0, 1'b1, OS, -1);
        pin("ff", 8'hFF, 1'b0, 1'b0, 6);
        check("b2b_spacing", last_dv - prev_dv, 704);

        // Stop bit cut to 9 ticks: next start edge lands on the tick after the stop centre.
        send_frame(8'h0F, 1'b0, 1'b1, OS / 2 + 1, -1);
        send_frame(8'hF0, 1'b0, 1'b1, OS, -1);
        pin("f0", 8'hF0, 1'b0, 1'b0, 8);
        check("early_spacing", last_dv - prev_dv, 676);
        check("early_starts",  de_count, 8);

        // Reset in the middle of data bit 4 of 0x12.
        @(negedge clk) rx_in = 1'b0;
        t0 = tick_cnt + 1;
        busy_on[t0]            = 1'b1;
        exp_start[t0 + OS / 2] = 1'b1;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) bit_slot(d12[i], OS, 1'b0);
        @(negedge clk) rx_in = d12[4];
        wait_ticks(OS / 2);
        @(negedge clk) begin
            reset = 1'b1;
            rx_in = 1'b1;
        end
        @(posedge clk);
        #2;
        check("mid_rst_busy",  busy,          0);
        check("mid_rst_valid", data_valid,    0);
        check("mid_rst_data",  data_out,      0);
        check("mid_rst_perr",  parity_error,  0);
        check("mid_rst_ferr",  framing_error, 0);
        @(negedge clk) reset = 1'b0;
        wait_ticks(OS);
        check("mid_rst_valids", dv_count, 8);
        send_frame(8'h12, 1'b0, 1'b1, OS, -1);
        pin("r12", 8'h12, 1'b0, 1'b0, 9);
        check("r12_starts", de_count, 10);

        wait_ticks(OS);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
